// File: rtl/boot_loader_if.sv
// Bring-up bus bundle around boot_loader: the UART RX byte stream, the CPU's
// RAM request lines and the RAM port that the loader drives.
//
// Byte handshake: the receiver holds rx_valid and rx_data steady until it sees
// rx_rd; a byte is transferred in exactly the cycles where rx_valid && rx_rd,
// and rx_rd is never raised without rx_valid.
interface boot_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_rd;

    logic        cpu_mem_re;
    logic        cpu_mem_we;
    logic [0:15] cpu_mem_raddr;
    logic [0:15] cpu_mem_waddr;
    logic [0:15] cpu_mem_wdata;

    logic        ram_re;
    logic        ram_we;
    logic [0:15] ram_raddr;
    logic [0:15] ram_waddr;
    logic [0:15] ram_wdata;

    // Loader side: owns rx_rd and the RAM port.
    modport master (
        input  rx_valid, rx_data,
        input  cpu_mem_re, cpu_mem_we, cpu_mem_raddr, cpu_mem_waddr, cpu_mem_wdata,
        output rx_rd,
        output ram_re, ram_we, ram_raddr, ram_waddr, ram_wdata
    );

    // Environment side: UART receiver, CPU and RAM.
    modport slave (
        output rx_valid, rx_data,
        output cpu_mem_re, cpu_mem_we, cpu_mem_raddr, cpu_mem_waddr, cpu_mem_wdata,
        input  rx_rd,
        input  ram_re, ram_we, ram_raddr, ram_waddr, ram_wdata
    );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: after a fixed hold-off either releases the CPU immediately or
// loads a framed, checksummed program image from the UART into the program
// RAM, then hands the RAM port to the CPU by combinational pass-through.
// Frame: 0x55, LEN_HI, LEN_LO, 2*N payload bytes (high byte first), CSUM,
// where CSUM is the XOR of LEN_HI, LEN_LO and every payload byte.
// o_state exposes the FSM encoding: HOLD=0 SYNC=1 LEN_HI=2 LEN_LO=3
// DATA_HI=4 DATA_LO=5 CSUM=6 RUN=7 ERROR=8.
module boot_loader #(
    parameter int HOLDOFF      = 40,
    parameter int BYTE_TIMEOUT = 1200000,
    parameter int MEM_WORDS    = 4096
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_boot_skip,
    boot_loader_if.master bus,
    output logic          o_cpu_run,
    output logic          o_load_error,
    output logic          o_busy,
    output logic [0:15]   o_words_loaded,
    output logic [3:0]    o_state
);
    localparam logic [7:0] SYNC_BYTE = 8'h55;

    typedef enum logic [3:0] {
        S_HOLD    = 4'd0,
        S_SYNC    = 4'd1,
        S_LEN_HI  = 4'd2,
        S_LEN_LO  = 4'd3,
        S_DATA_HI = 4'd4,
        S_DATA_LO = 4'd5,
        S_CSUM    = 4'd6,
        S_RUN     = 4'd7,
        S_ERROR   = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_hold_cnt;
    logic [31:0] r_idle_cnt;
    logic        r_acc_prev;
    logic [7:0]  r_len_hi;
    logic [7:0]  r_hi;
    logic [7:0]  r_csum;
    logic [0:15] r_len;
    // words_loaded doubles as the write address counter.
    logic [0:15] r_words;
    logic        r_we;
    logic [0:15] r_waddr;
    logic [0:15] r_wdata;

    logic        w_rx_state;
    logic        w_timed_state;
    logic        w_accept;
    logic        w_timeout;
    logic        w_hold_done;
    logic        w_oversize;
    logic        w_last_word;
    logic [7:0]  w_byte;
    logic [0:15] w_len;

    assign w_byte        = bus.rx_data;
    assign w_rx_state    = (r_state >= S_SYNC) && (r_state <= S_CSUM);
    assign w_timed_state = (r_state >= S_LEN_HI) && (r_state <= S_CSUM);
    // Accepts are spaced by at least one idle cycle so rx_rd never stays high.
    assign w_accept      = w_rx_state && bus.rx_valid && !r_acc_prev;
    // An accept in the same cycle wins over the timeout.
    assign w_timeout     = w_timed_state && !w_accept && (r_idle_cnt == 32'(BYTE_TIMEOUT));
    assign w_hold_done   = (r_hold_cnt == 32'(HOLDOFF));
    assign w_len         = {r_len_hi, w_byte};
    assign w_oversize    = ({16'd0, w_len} > 32'(MEM_WORDS));
    assign w_last_word   = ((r_words + 16'd1) == r_len);

    assign bus.rx_rd      = w_accept;
    assign o_cpu_run      = (r_state == S_RUN);
    assign o_load_error   = (r_state == S_ERROR);
    assign o_busy         = (r_state != S_RUN) && (r_state != S_ERROR);
    assign o_words_loaded = r_words;
    assign o_state        = r_state;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_HOLD;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic; a byte only moves the machine on an accept.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HOLD:    if (w_hold_done) w_next = i_boot_skip ? S_RUN : S_SYNC;
            S_SYNC:    if (w_accept && (w_byte == SYNC_BYTE)) w_next = S_LEN_HI;
            S_LEN_HI:  if (w_accept) w_next = S_LEN_LO;
            S_LEN_LO: begin
                if (w_accept) begin
                    if (w_oversize)         w_next = S_ERROR;
                    else if (w_len == 16'd0) w_next = S_CSUM;
                    else                    w_next = S_DATA_HI;
                end
            end
            S_DATA_HI: if (w_accept) w_next = S_DATA_LO;
            S_DATA_LO: if (w_accept) w_next = w_last_word ? S_CSUM : S_DATA_HI;
            S_CSUM:    if (w_accept) w_next = (w_byte == r_csum) ? S_RUN : S_ERROR;
            S_RUN:     w_next = S_RUN;
            S_ERROR:   w_next = S_ERROR;
            default:   w_next = S_HOLD;
        endcase
        if (w_timeout) w_next = S_SYNC;
    end

    // Datapath: hold-off and idle counters, frame fields, checksum and the registered write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold_cnt <= '0;
            r_idle_cnt <= '0;
            r_acc_prev <= 1'b0;
            r_len_hi   <= '0;
            r_hi       <= '0;
            r_csum     <= '0;
            r_len      <= '0;
            r_words    <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_acc_prev <= w_accept;
            r_we       <= 1'b0;
            if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt + 32'd1;
            if (!w_timed_state || w_accept) r_idle_cnt <= '0;
            else                            r_idle_cnt <= r_idle_cnt + 32'd1;
            if (w_accept) begin
                case (r_state)
                    S_SYNC: begin
                        if (w_byte == SYNC_BYTE) begin
                            r_csum  <= '0;
                            r_words <= '0;
                        end
                    end
                    S_LEN_HI: begin
                        r_len_hi <= w_byte;
                        r_csum   <= r_csum ^ w_byte;
                    end
                    S_LEN_LO: begin
                        r_len  <= w_len;
                        r_csum <= r_csum ^ w_byte;
                    end
                    S_DATA_HI: begin
                        r_hi   <= w_byte;
                        r_csum <= r_csum ^ w_byte;
                    end
                    S_DATA_LO: begin
                        r_we    <= 1'b1;
                        r_waddr <= r_words;
                        r_wdata <= {r_hi, w_byte};
                        r_words <= r_words + 16'd1;
                        r_csum  <= r_csum ^ w_byte;
                    end
                    default: ;
                endcase
            end
        end
    end

    // RAM port: CPU pass-through in RUN, otherwise only the loader's write pulse.
    always_comb begin
        bus.ram_re    = 1'b0;
        bus.ram_we    = r_we;
        bus.ram_raddr = '0;
        bus.ram_waddr = r_waddr;
        bus.ram_wdata = r_wdata;
        if (r_state == S_RUN) begin
            bus.ram_re    = bus.cpu_mem_re;
            bus.ram_we    = bus.cpu_mem_we;
            bus.ram_raddr = bus.cpu_mem_raddr;
            bus.ram_waddr = bus.cpu_mem_waddr;
            bus.ram_wdata = bus.cpu_mem_wdata;
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a byte FIFO stands in for the UART receiver
// and a 4096x16 array with one-cycle read latency stands in for the RAM.
module tb_boot_loader;
    localparam int HOLDOFF      = 40;
    localparam int BYTE_TIMEOUT = 200;
    localparam int MEM_WORDS    = 4096;

    localparam logic [3:0] ST_HOLD    = 4'd0;
    localparam logic [3:0] ST_SYNC    = 4'd1;
    localparam logic [3:0] ST_DATA_HI = 4'd4;
    localparam logic [3:0] ST_DATA_LO = 4'd5;
    localparam logic [3:0] ST_RUN     = 4'd7;
    localparam logic [3:0] ST_ERROR   = 4'd8;

    logic        clk;
    logic        reset;
    logic        boot_skip;
    logic        cpu_run;
    logic        load_error;
    logic        busy;
    logic [0:15] words_loaded;
    logic [3:0]  state;

    boot_loader_if bif ();

    int checks   = 0;
    int failures = 0;

    logic [7:0]  byte_mem [0:63];
    int          wr_cnt    = 0;
    int          rd_ptr    = 0;
    logic        fifo_clr  = 1'b0;
    logic [15:0] tb_ram [0:4095];
    logic [15:0] ram_rdata;
    int          we_count  = 0;
    int          b2b_count = 0;
    logic        prev_rd   = 1'b0;

    boot_loader #(
        .HOLDOFF(HOLDOFF),
        .BYTE_TIMEOUT(BYTE_TIMEOUT),
        .MEM_WORDS(MEM_WORDS)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_boot_skip(boot_skip),
        .bus(bif),
        .o_cpu_run(cpu_run),
        .o_load_error(load_error),
        .o_busy(busy),
        .o_words_loaded(words_loaded),
        .o_state(state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // UART receiver model: head of the FIFO is presented until rx_rd pops it.
    assign bif.rx_valid = (rd_ptr < wr_cnt);
    assign bif.rx_data  = byte_mem[rd_ptr[5:0]];

    // FIFO read pointer and rx_rd spacing monitor.
    always @(posedge clk) begin
        if (fifo_clr) rd_ptr <= 0;
        else if (bif.rx_rd) rd_ptr <= rd_ptr + 1;
        prev_rd <= bif.rx_rd;
        if (bif.rx_rd && prev_rd) b2b_count <= b2b_count + 1;
    end

    // RAM model plus a count of loader-driven write pulses.
    always @(posedge clk) begin
        if (bif.ram_we) tb_ram[bif.ram_waddr[4:15]] <= bif.ram_wdata;
        if (bif.ram_re) ram_rdata <= tb_ram[bif.ram_raddr[4:15]];
        if (bif.ram_we && !cpu_run) we_count <= we_count + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        byte_mem[wr_cnt[5:0]] = b;
        wr_cnt = wr_cnt + 1;
    endtask

    task automatic idle_cpu();
        bif.cpu_mem_re    = 1'b0;
        bif.cpu_mem_we    = 1'b0;
        bif.cpu_mem_raddr = '0;
        bif.cpu_mem_waddr = '0;
        bif.cpu_mem_wdata = '0;
    endtask

    // Two reset cycles with an emptied FIFO; returns just after reset drops.
    task automatic do_reset(input logic skip);
        reset = 1'b1;
        boot_skip = skip;
        idle_cpu();
        fifo_clr = 1'b1;
        wr_cnt = 0;
        step(2);
        fifo_clr = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        boot_skip = 1'b0;
        fifo_clr = 1'b1;
        wr_cnt = 0;
        step(1);
        fifo_clr = 1'b0;
        push_byte(8'h55);
        push_byte(8'hAA);
        bif.cpu_mem_re = 1'b1;
        bif.cpu_mem_we = 1'b1;
        bif.cpu_mem_raddr = 16'h0003;
        bif.cpu_mem_waddr = 16'h0003;
        bif.cpu_mem_wdata = 16'hFFFF;
        step(1);
        checks++; if (state !== ST_HOLD) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", state, ST_HOLD); end
        checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL rst_cpu_run got=%0b exp=0", cpu_run); end
        checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL rst_load_error got=%0b exp=0", load_error); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%0b exp=1", busy); end
        checks++; if (bif.rx_rd !== 1'b0) begin failures++; $display("FAIL rst_rx_rd got=%0b exp=0", bif.rx_rd); end
        checks++; if (bif.ram_we !== 1'b0) begin failures++; $display("FAIL rst_ram_we got=%0b exp=0", bif.ram_we); end
        checks++; if (bif.ram_re !== 1'b0) begin failures++; $display("FAIL rst_ram_re got=%0b exp=0", bif.ram_re); end
        checks++; if (words_loaded !== 16'h0000) begin failures++; $display("FAIL rst_words got=%0h exp=0", words_loaded); end
        checks++; if (bif.ram_waddr !== 16'h0000) begin failures++; $display("FAIL rst_ram_waddr got=%0h exp=0", bif.ram_waddr); end
        checks++; if (bif.ram_wdata !== 16'h0000) begin failures++; $display("FAIL rst_ram_wdata got=%0h exp=0", bif.ram_wdata); end
        reset = 1'b0;
        step(10);
        // Still holding off: UART byte waits, CPU requests do not reach RAM.
        checks++; if (state !== ST_HOLD) begin failures++; $display("FAIL hold_state got=%0d exp=%0d", state, ST_HOLD); end
        checks++; if (bif.ram_re !== 1'b0) begin failures++; $display("FAIL hold_ram_re got=%0b exp=0", bif.ram_re); end
        checks++; if (rd_ptr !== 0) begin failures++; $display("FAIL hold_rx_consumed got=%0d exp=0", rd_ptr); end
        idle_cpu();
    endtask

    task automatic test_skip();
        do_reset(1'b1);
        push_byte(8'h55);
        push_byte(8'h00);
        step(HOLDOFF);
        checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL skip_cpu_run_early got=%0b exp=0", cpu_run); end
        step(1);
        checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL skip_cpu_run_41 got=%0b exp=1", cpu_run); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL skip_busy got=%0b exp=0", busy); end
        bif.cpu_mem_we = 1'b1;
        bif.cpu_mem_waddr = 16'h0005;
        bif.cpu_mem_wdata = 16'h5A05;
        #1;
        checks++; if (bif.ram_we !== 1'b1) begin failures++; $display("FAIL skip_pass_we got=%0b exp=1", bif.ram_we); end
        checks++; if (bif.ram_waddr !== 16'h0005) begin failures++; $display("FAIL skip_pass_waddr got=%0h exp=5", bif.ram_waddr); end
        checks++; if (bif.ram_wdata !== 16'h5A05) begin failures++; $display("FAIL skip_pass_wdata got=%0h exp=5a05", bif.ram_wdata); end
        step(1);
        bif.cpu_mem_we = 1'b0;
        bif.cpu_mem_re = 1'b1;
        bif.cpu_mem_raddr = 16'h0005;
        #1;
        checks++; if (bif.ram_re !== 1'b1) begin failures++; $display("FAIL skip_pass_re got=%0b exp=1", bif.ram_re); end
        checks++; if (bif.ram_raddr !== 16'h0005) begin failures++; $display("FAIL skip_pass_raddr got=%0h exp=5", bif.ram_raddr); end
        step(1);
        bif.cpu_mem_re = 1'b0;
        checks++; if (ram_rdata !== 16'h5A05) begin failures++; $display("FAIL skip_read5 got=%0h exp=5a05", ram_rdata); end
        step(5);
        checks++; if (rd_ptr !== 0) begin failures++; $display("FAIL skip_rx_rd got=%0d pops exp=0", rd_ptr); end
    endtask

    task automatic test_normal_load();
        int we0;
        do_reset(1'b0);
        we0 = we_count;
        // CSUM = 0x00^0x02^0x12^0x34^0xAB^0xCD = 0x42
        push_byte(8'h55); push_byte(8'h00); push_byte(8'h02); push_byte(8'h12);
        push_byte(8'h34); push_byte(8'hAB); push_byte(8'hCD); push_byte(8'h42);
        step(HOLDOFF + 1);
        for (int i = 0; i < 100; i++) begin
            if (cpu_run === 1'b1 || load_error === 1'b1) break;
            step(1);
        end
        checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL load_cpu_run got=%0b exp=1", cpu_run); end
        checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL load_error got=%0b exp=0", load_error); end
        checks++; if (state !== ST_RUN) begin failures++; $display("FAIL load_state got=%0d exp=%0d", state, ST_RUN); end
        checks++; if (words_loaded !== 16'd2) begin failures++; $display("FAIL load_words got=%0d exp=2", words_loaded); end
        checks++; if (tb_ram[0] !== 16'h1234) begin failures++; $display("FAIL load_ram0 got=%0h exp=1234", tb_ram[0]); end
        checks++; if (tb_ram[1] !== 16'hABCD) begin failures++; $display("FAIL load_ram1 got=%0h exp=abcd", tb_ram[1]); end
        checks++; if (we_count - we0 !== 2) begin failures++; $display("FAIL load_we_pulses got=%0d exp=2", we_count - we0); end
        checks++; if (rd_ptr !== 8) begin failures++; $display("FAIL load_bytes_consumed got=%0d exp=8", rd_ptr); end
    endtask

    task automatic test_bad_csum();
        do_reset(1'b0);
        push_byte(8'h55); push_byte(8'h00); push_byte(8'h02); push_byte(8'h12);
        push_byte(8'h34); push_byte(8'hAB); push_byte(8'hCD); push_byte(8'h00);
        push_byte(8'h55); push_byte(8'h00);
        step(HOLDOFF + 1);
        for (int i = 0; i < 100; i++) begin
            if (cpu_run === 1'b1 || load_error === 1'b1) break;
            step(1);
        end
        checks++; if (load_error !== 1'b1) begin failures++; $display("FAIL csum_load_error got=%0b exp=1", load_error); end
        checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL csum_cpu_run got=%0b exp=0", cpu_run); end
        checks++; if (state !== ST_ERROR) begin failures++; $display("FAIL csum_state got=%0d exp=%0d", state, ST_ERROR); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL csum_busy got=%0b exp=0", busy); end
        step(20);
        checks++; if (rd_ptr !== 8) begin failures++; $display("FAIL csum_later_bytes got=%0d exp=8", rd_ptr); end
        checks++; if (load_error !== 1'b1) begin failures++; $display("FAIL csum_sticky got=%0b exp=1", load_error); end
    endtask

    task automatic test_garbage();
        do_reset(1'b0);
        // CSUM = 0x00^0x02^0x0F^0xF0^0x96^0x69 = 0x02
        push_byte(8'hFF); push_byte(8'h00);
        push_byte(8'h55); push_byte(8'h00); push_byte(8'h02); push_byte(8'h0F);
        push_byte(8'hF0); push_byte(8'h96); push_byte(8'h69); push_byte(8'h02);
        step(HOLDOFF + 1);
        step(4);
        checks++; if (rd_ptr !== 2) begin failures++; $display("FAIL garbage_consumed got=%0d exp=2", rd_ptr); end
        checks++; if (state !== ST_SYNC) begin failures++; $display("FAIL garbage_state got=%0d exp=%0d", state, ST_SYNC); end
        for (int i = 0; i < 100; i++) begin
            if (cpu_run === 1'b1 || load_error === 1'b1) break;
            step(1);
        end
        checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL garbage_cpu_run got=%0b exp=1", cpu_run); end
        checks++; if (words_loaded !== 16'd2) begin failures++; $display("FAIL garbage_words got=%0d exp=2", words_loaded); end
        checks++; if (tb_ram[0] !== 16'h0FF0) begin failures++; $display("FAIL garbage_ram0 got=%0h exp=0ff0", tb_ram[0]); end
        checks++; if (tb_ram[1] !== 16'h9669) begin failures++; $display("FAIL garbage_ram1 got=%0h exp=9669", tb_ram[1]); end
        checks++; if (rd_ptr !== 10) begin failures++; $display("FAIL garbage_total got=%0d exp=10", rd_ptr); end
    endtask

    task automatic test_len_bounds();
        int we0;
        // LEN = 0x1001 is one past the RAM depth.
        do_reset(1'b0);
        we0 = we_count;
        push_byte(8'h55); push_byte(8'h10); push_byte(8'h01); push_byte(8'hAA); push_byte(8'hBB);
        step(HOLDOFF + 1);
        for (int i = 0; i < 50; i++) begin
            if (state === ST_ERROR) break;
            step(1);
        end
        step(10);
        checks++; if (state !== ST_ERROR) begin failures++; $display("FAIL oversize_state got=%0d exp=%0d", state, ST_ERROR); end
        checks++; if (load_error !== 1'b1) begin failures++; $display("FAIL oversize_error got=%0b exp=1", load_error); end
        checks++; if (we_count !== we0) begin failures++; $display("FAIL oversize_we got=%0d exp=%0d", we_count, we0); end
        checks++; if (rd_ptr !== 3) begin failures++; $display("FAIL oversize_consumed got=%0d exp=3", rd_ptr); end
        // LEN = 0x1000 is exactly the RAM depth and is accepted.
        do_reset(1'b0);
        push_byte(8'h55); push_byte(8'h10); push_byte(8'h00);
        step(HOLDOFF + 1);
        for (int i = 0; i < 50; i++) begin
            if (state === ST_DATA_HI || state === ST_ERROR) break;
            step(1);
        end
        checks++; if (state !== ST_DATA_HI) begin failures++; $display("FAIL maxlen_state got=%0d exp=%0d", state, ST_DATA_HI); end
        checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL maxlen_error got=%0b exp=0", load_error); end
        // LEN = 0 goes straight to CSUM; CSUM = 0x00^0x00 = 0x00.
        do_reset(1'b0);
        we0 = we_count;
        push_byte(8'h55); push_byte(8'h00); push_byte(8'h00); push_byte(8'h00);
        step(HOLDOFF + 1);
        for (int i = 0; i < 50; i++) begin
            if (cpu_run === 1'b1 || load_error === 1'b1) break;
            step(1);
        end
        checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL zerolen_cpu_run got=%0b exp=1", cpu_run); end
        checks++; if (words_loaded !== 16'd0) begin failures++; $display("FAIL zerolen_words got=%0d exp=0", words_loaded); end
        checks++; if (we_count !== we0) begin failures++; $display("FAIL zerolen_we got=%0d exp=%0d", we_count, we0); end
    endtask

    task automatic test_timeout();
        do_reset(1'b0);
        push_byte(8'h55); push_byte(8'h00); push_byte(8'h01); push_byte(8'hC3);
        step(HOLDOFF + 1);
        for (int i = 0; i < 50; i++) begin
            if (state === ST_DATA_LO) break;
            step(1);
        end
        checks++; if (state !== ST_DATA_LO) begin failures++; $display("FAIL timeout_reach_lo got=%0d exp=%0d", state, ST_DATA_LO); end
        step(BYTE_TIMEOUT - 20);
        checks++; if (state !== ST_DATA_LO) begin failures++; $display("FAIL timeout_early got=%0d exp=%0d", state, ST_DATA_LO); end
        step(40);
        checks++; if (state !== ST_SYNC) begin failures++; $display("FAIL timeout_to_sync got=%0d exp=%0d", state, ST_SYNC); end
        // Resend a full one-word frame: CSUM = 0x00^0x01^0xC3^0x3C = 0xFE.
        push_byte(8'h55); push_byte(8'h00); push_byte(8'h01); push_byte(8'hC3);
        push_byte(8'h3C); push_byte(8'hFE);
        for (int i = 0; i < 100; i++) begin
            if (cpu_run === 1'b1 || load_error === 1'b1) break;
            step(1);
        end
        checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL timeout_reload_run got=%0b exp=1", cpu_run); end
        checks++; if (tb_ram[0] !== 16'hC33C) begin failures++; $display("FAIL timeout_reload_ram0 got=%0h exp=c33c", tb_ram[0]); end
        checks++; if (words_loaded !== 16'd1) begin failures++; $display("FAIL timeout_reload_words got=%0d exp=1", words_loaded); end
    endtask

    task automatic test_reset_mid_load();
        do_reset(1'b0);
        push_byte(8'h55); push_byte(8'h00); push_byte(8'h02); push_byte(8'h12);
        push_byte(8'h34); push_byte(8'hAB);
        step(HOLDOFF + 1);
        for (int i = 0; i < 50; i++) begin
            if (state === ST_DATA_LO && words_loaded === 16'd1) break;
            step(1);
        end
        checks++; if (words_loaded !== 16'd1) begin failures++; $display("FAIL midrst_pre_words got=%0d exp=1", words_loaded); end
        reset = 1'b1;
        step(1);
        checks++; if (state !== ST_HOLD) begin failures++; $display("FAIL midrst_state got=%0d exp=%0d", state, ST_HOLD); end
        checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL midrst_cpu_run got=%0b exp=0", cpu_run); end
        checks++; if (words_loaded !== 16'd0) begin failures++; $display("FAIL midrst_words got=%0d exp=0", words_loaded); end
        reset = 1'b0;
        step(HOLDOFF + 1);
        checks++; if (state !== ST_SYNC) begin failures++; $display("FAIL midrst_resync got=%0d exp=%0d", state, ST_SYNC); end
    endtask

    task automatic test_back_to_back();
        checks++; if (b2b_count !== 0) begin failures++; $display("FAIL rx_rd_back_to_back got=%0d exp=0", b2b_count); end
    endtask

    initial begin
        reset = 1'b1;
        boot_skip = 1'b0;
        idle_cpu();
        test_reset();
        test_skip();
        test_normal_load();
        test_bad_csum();
        test_garbage();
        test_len_bounds();
        test_timeout();
        test_reset_mid_load();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
